mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
// Main control unit for the multicycle MIPS core. It replaces the single-cycle controller and
// sequences the shared memory, ALU and register file across several clock cycles per instruction.
// It is a Moore FSM over op/funct/zero from the datapath and drives every datapath mux select
// and write enable. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
// PARAMETERS
// ILLEGAL_TRAP  1  1: an unknown opcode parks the FSM in HALT until reset; 0: it returns to FETCH.
// PORTS
// clk         in   1  clock; all state updates on the rising edge
// reset       in   1  synchronous, active-high; state <= FETCH on the next rising edge
// op          in   6  instr[31:26] from the instruction register
// funct       in   6  instr[5:0] from the instruction register
// zero        in   1  ALU zero flag
// pcen        out  1  PC register enable = pcwrite | (branch & zero)
// irwrite     out  1  instruction register enable
// memwrite    out  1  data memory write enable
// regwrite    out  1  register file write enable
// iord        out  1  memory address select: 0 = PC, 1 = ALUOut
// memtoreg    out  1  writeback select: 0 = ALUOut, 1 = Data register
// regdst      out  1  destination register: 0 = rt, 1 = rd
// alusrca     out  1  ALU A select: 0 = PC, 1 = A register
// alusrcb     out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
// pcsrc       out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
// alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
// illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported
// halted      out  1  high while in HALT
// BEHAVIOUR
// - 4-bit state register. Outputs decode from the state only, except pcen, which also uses zero.
//   Any output not listed for a state is 0.
// - While reset=1, all write enables (pcen, irwrite, memwrite, regwrite) are forced to 0.
//   The state register is FETCH after the reset edge.
// - Reset asserted mid-instruction abandons that instruction; no partial writes occur.
// - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
// - DECODE: alusrcb=11, aluop=00. op selects the next state:
//   lw/sw -> MEMADR, 000000 -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX,
//   other -> HALT or FETCH per ILLEGAL_TRAP.
// - MEMADR: alusrca=1, alusrcb=10 -> MEMRD if lw (100011), MEMWR if sw (101011).
// - MEMRD: iord=1 -> MEMWB.  MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
// - MEMWR: iord=1, memwrite=1 -> FETCH.
// - RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.  RTYPEWB: regdst=1, regwrite=1 -> FETCH.
// - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
// - ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB.  ADDIWB: regdst=0, regwrite=1 -> FETCH.
// - JEX: pcsrc=10, pcwrite=1 -> FETCH.
// - HALT: every enable is 0; halted=1; leaves only on reset.
// - Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3.
// - ALU decode: aluop 00 -> 010, 01 -> 110, 10 -> by funct
//   (100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, else 010).
//   aluop 11 is not produced.
// - op and funct are sampled combinationally; the IR holds them stable from DECODE to the
//   end of the instruction.
// STRUCTURE
// - Package mips_ctrl_pkg: statetype enum (FETCH..HALT, 4 bits), opcode localparams
//   OP_LW/OP_SW/OP_RTYPE/OP_BEQ/OP_ADDI/OP_J, funct and alucontrol localparams.
// - One sub-module: mips_alu_decoder (aluop, funct -> alucontrol), purely combinational.
// - The top holds the state register, next-state logic and the output decode.
// TESTING
// - lw (op=100011): 5 cycles FETCH,DECODE,MEMADR,MEMRD,MEMWB -> regwrite=1 and memtoreg=1
//   only in MEMWB; irwrite=1 only in FETCH.
// - sw (op=101011): 4 cycles -> memwrite=1 with iord=1 exactly one cycle (MEMWR); regwrite
//   never 1. Full-core check: memwrite at addr 68 with data 5.
// - beq: zero=1 -> pcen=1, pcsrc=01 in BEQEX; zero=0 -> pcen=0 in BEQEX;
//   both return to FETCH in 3 cycles.
// - R-type funct=100010 -> alucontrol=110 in RTYPEEX; funct=101010 -> 111;
//   regdst=1 in RTYPEWB.
// - op=111111: illegal_op pulses in DECODE. ILLEGAL_TRAP=1 -> halted=1 and stays,
//   all enables 0 for 20 cycles; ILLEGAL_TRAP=0 -> FETCH next cycle.
// - Reset asserted during MEMRD of lw -> no regwrite; FETCH after the edge;
//   enables 0 while reset=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        HALT    = 4'd12
    } statetype;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Raw per-state control word before reset gating and branch resolution.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle (instruction fields in, selects/enables out).
// Latency: n/a (wires only).
// Backpressure: none; the datapath consumes the controls every cycle.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       halted;

    modport master (
        input  op, funct, zero,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, halted
    );

    modport slave (
        output op, funct, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, halted
    );
endinterface

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU operation decoder: aluop class plus R-type funct to ALU control code.
// Latency: purely combinational.
// Backpressure: none.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch math; funct decides for R-type.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller sequencing fetch/decode/execute/memory/writeback for the multicycle core.
// Latency: 3-5 cycles per instruction (lw 5; sw, R-type, addi 4; beq, j 3).
// Backpressure: none; unknown opcodes either park in HALT or restart at FETCH.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
)(
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);

    statetype   state;
    statetype   nextstate;
    ctrl_t      c;
    logic [2:0] alucontrol;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= nextstate;
    end

    // Next-state selection and per-state control word.
    always_comb begin
        nextstate = FETCH;
        c         = '0;
        case (state)
            FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                nextstate = DECODE;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: nextstate = MEMADR;
                    OP_RTYPE:     nextstate = RTYPEEX;
                    OP_BEQ:       nextstate = BEQEX;
                    OP_ADDI:      nextstate = ADDIEX;
                    OP_J:         nextstate = JEX;
                    default:      nextstate = ILLEGAL_TRAP ? HALT : FETCH;
                endcase
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                if (bus.op == OP_LW)      nextstate = MEMRD;
                else if (bus.op == OP_SW) nextstate = MEMWR;
                else                      nextstate = FETCH;
            end
            MEMRD: begin
                c.iord    = 1'b1;
                nextstate = MEMWB;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                nextstate  = FETCH;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                nextstate  = FETCH;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
                nextstate = RTYPEWB;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                nextstate  = FETCH;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
                nextstate = FETCH;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                nextstate = ADDIWB;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
                nextstate  = FETCH;
            end
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
                nextstate = FETCH;
            end
            HALT: begin
                c.halted  = 1'b1;
                nextstate = HALT;
            end
            default: nextstate = FETCH;
        endcase
    end

    mips_alu_decoder u_aludec (
        .aluop      (c.aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol)
    );

    // Write enables are held low during reset so an abandoned instruction never commits.
    assign bus.pcen       = ~reset & (c.pcwrite | (c.branch & bus.zero));
    assign bus.irwrite    = ~reset & c.irwrite;
    assign bus.memwrite   = ~reset & c.memwrite;
    assign bus.regwrite   = ~reset & c.regwrite;
    assign bus.iord       = c.iord;
    assign bus.memtoreg   = c.memtoreg;
    assign bus.regdst     = c.regdst;
    assign bus.alusrca    = c.alusrca;
    assign bus.alusrcb    = c.alusrcb;
    assign bus.pcsrc      = c.pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.illegal_op = (state == DECODE) && !is_legal_op(bus.op);
    assign bus.halted     = c.halted;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if if0 ();
    mips_multicycle_ctrl_if if1 ();

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic       halted;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         ncyc;
        logic [7:0] rw_mask;
        logic [7:0] mw_mask;
        logic [7:0] pcen_mask;
        logic [2:0] aluc2;
    } vec_t;

    out_t exp_q[$];

    function automatic out_t snap0();
        out_t o;
        o = {if0.pcen, if0.irwrite, if0.memwrite, if0.regwrite, if0.iord, if0.memtoreg,
             if0.regdst, if0.alusrca, if0.alusrcb, if0.pcsrc, if0.alucontrol,
             if0.illegal_op, if0.halted};
        return o;
    endfunction

    function automatic out_t snap1();
        out_t o;
        o = {if1.pcen, if1.irwrite, if1.memwrite, if1.regwrite, if1.iord, if1.memtoreg,
             if1.regdst, if1.alusrca, if1.alusrcb, if1.pcsrc, if1.alucontrol,
             if1.illegal_op, if1.halted};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: each instruction is a list of cycle control words.
    function automatic out_t base_o();
        out_t o = '0;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    function automatic out_t fetch_o();
        out_t o = base_o();
        o.pcen = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01;
        return o;
    endfunction

    function automatic out_t decode_o(input logic ill);
        out_t o = base_o();
        o.alusrcb = 2'b11; o.illegal_op = ill;
        return o;
    endfunction

    function automatic out_t halt_o();
        out_t o = base_o();
        o.halted = 1'b1;
        return o;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        logic [2:0] r = 3'b010;
        if (f == 6'b100010) r = 3'b110;
        if (f == 6'b100100) r = 3'b000;
        if (f == 6'b100101) r = 3'b001;
        if (f == 6'b101010) r = 3'b111;
        return r;
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] f, input logic z);
        out_t o;
        exp_q.delete();
        exp_q.push_back(fetch_o());
        exp_q.push_back(decode_o(1'b0));
        if (op == OP_LW || op == OP_SW) begin
            o = base_o(); o.alusrca = 1'b1; o.alusrcb = 2'b10; exp_q.push_back(o);
            if (op == OP_LW) begin
                o = base_o(); o.iord = 1'b1; exp_q.push_back(o);
                o = base_o(); o.memtoreg = 1'b1; o.regwrite = 1'b1; exp_q.push_back(o);
            end else begin
                o = base_o(); o.iord = 1'b1; o.memwrite = 1'b1; exp_q.push_back(o);
            end
        end else if (op == OP_RTYPE) begin
            o = base_o(); o.alusrca = 1'b1; o.alucontrol = ref_alu(f); exp_q.push_back(o);
            o = base_o(); o.regdst = 1'b1; o.regwrite = 1'b1; exp_q.push_back(o);
        end else if (op == OP_BEQ) begin
            o = base_o(); o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
            o.pcen = z; exp_q.push_back(o);
        end else if (op == OP_ADDI) begin
            o = base_o(); o.alusrca = 1'b1; o.alusrcb = 2'b10; exp_q.push_back(o);
            o = base_o(); o.regwrite = 1'b1; exp_q.push_back(o);
        end else begin
            o = base_o(); o.pcsrc = 2'b10; o.pcen = 1'b1; exp_q.push_back(o);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] f, input logic z);
        if0.op = op; if0.funct = f; if0.zero = z;
        if1.op = op; if1.funct = f; if1.zero = z;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts at a negedge with both DUTs in FETCH; ends at the next FETCH negedge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input string tag);
        build(op, f, z);
        drive(op, f, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            chk($sformatf("%s cyc%0d dut0", tag, i), 32'(snap0()), 32'(exp_q[i]));
            chk($sformatf("%s cyc%0d dut1", tag, i), 32'(snap1()), 32'(exp_q[i]));
            @(negedge clk);
        end
    endtask

    vec_t vecs[11];
    logic [5:0] ops[6];

    initial begin
        out_t o;
        int   ncyc;
        logic [7:0] rw, mw, pc;
        logic [2:0] a2;

        vecs[0]  = '{OP_LW,    6'h00, 1'b0, 5, 8'b10000, 8'b0000, 8'b00001, 3'b010};
        vecs[1]  = '{OP_SW,    6'h00, 1'b0, 4, 8'b0000,  8'b1000, 8'b0001,  3'b010};
        vecs[2]  = '{OP_RTYPE, 6'h22, 1'b0, 4, 8'b1000,  8'b0000, 8'b0001,  3'b110};
        vecs[3]  = '{OP_RTYPE, 6'h2A, 1'b1, 4, 8'b1000,  8'b0000, 8'b0001,  3'b111};
        vecs[4]  = '{OP_RTYPE, 6'h24, 1'b0, 4, 8'b1000,  8'b0000, 8'b0001,  3'b000};
        vecs[5]  = '{OP_RTYPE, 6'h25, 1'b0, 4, 8'b1000,  8'b0000, 8'b0001,  3'b001};
        vecs[6]  = '{OP_RTYPE, 6'h3F, 1'b0, 4, 8'b1000,  8'b0000, 8'b0001,  3'b010};
        vecs[7]  = '{OP_BEQ,   6'h00, 1'b1, 3, 8'b000,   8'b000,  8'b101,   3'b110};
        vecs[8]  = '{OP_BEQ,   6'h00, 1'b0, 3, 8'b000,   8'b000,  8'b001,   3'b110};
        vecs[9]  = '{OP_ADDI,  6'h00, 1'b0, 4, 8'b1000,  8'b0000, 8'b0001,  3'b010};
        vecs[10] = '{OP_J,     6'h00, 1'b0, 3, 8'b000,   8'b000,  8'b101,   3'b010};
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};

        reset = 1'b1;
        drive(6'h00, 6'h20, 1'b0);
        do_reset();

        // Reset state: FETCH controls right after reset releases.
        #1;
        chk("reset_state dut0", 32'(snap0()), 32'(fetch_o()));
        chk("reset_state dut1", 32'(snap1()), 32'(fetch_o()));

        // Directed table: cycle count, per-cycle enable masks, execute-cycle ALU code.
        foreach (vecs[k]) begin
            drive(vecs[k].op, vecs[k].funct, vecs[k].zero);
            ncyc = 0; rw = '0; mw = '0; pc = '0; a2 = 3'bx;
            for (int cyc = 0; cyc < 8; cyc++) begin
                if (cyc > 0 && if0.irwrite) begin
                    ncyc = cyc;
                    break;
                end
                rw[cyc] = if0.regwrite;
                mw[cyc] = if0.memwrite;
                pc[cyc] = if0.pcen;
                if (cyc == 2) a2 = if0.alucontrol;
                @(negedge clk);
                #1;
            end
            chk($sformatf("vec%0d ncyc", k), 32'(ncyc), 32'(vecs[k].ncyc));
            chk($sformatf("vec%0d regwrite", k), 32'(rw), 32'(vecs[k].rw_mask));
            chk($sformatf("vec%0d memwrite", k), 32'(mw), 32'(vecs[k].mw_mask));
            chk($sformatf("vec%0d pcen", k), 32'(pc), 32'(vecs[k].pcen_mask));
            chk($sformatf("vec%0d aluc_ex", k), 32'(a2), 32'(vecs[k].aluc2));
            if (ncyc == 0) do_reset();
        end

        // Randomized legal instructions against the sequence model.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op, f;
            op = ops[$urandom_range(0, 5)];
            f  = 6'($urandom);
            if ($urandom_range(0, 1) == 1) f = 6'b100000 | 6'({$urandom_range(0, 1), 1'b0, $urandom_range(0, 1), 1'b0, $urandom_range(0, 1)});
            run_instr(op, f, 1'($urandom), $sformatf("rnd%0d op%h", n, op));
        end

        // Illegal opcode: pulse in DECODE, then FETCH (no trap) or HALT (trap).
        drive(6'b111111, 6'h00, 1'b1);
        #1;
        chk("ill fetch dut0", 32'(snap0()), 32'(fetch_o()));
        chk("ill fetch dut1", 32'(snap1()), 32'(fetch_o()));
        @(negedge clk); #1;
        chk("ill decode dut0", 32'(snap0()), 32'(decode_o(1'b1)));
        chk("ill decode dut1", 32'(snap1()), 32'(decode_o(1'b1)));
        @(negedge clk); #1;
        chk("ill notrap fetch", 32'(snap0()), 32'(fetch_o()));
        chk("ill trap halt", 32'(snap1()), 32'(halt_o()));
        if1.op = OP_LW;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk($sformatf("halt hold %0d", i), 32'(snap1()), 32'(halt_o()));
        end
        do_reset();
        #1;
        chk("post_halt reset dut1", 32'(snap1()), 32'(fetch_o()));

        // Reset during MEMRD of lw: no regwrite, enables low while reset is high.
        build(OP_LW, 6'h00, 1'b0);
        drive(OP_LW, 6'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk($sformatf("lwrst cyc%0d", i), 32'(snap0()), 32'(exp_q[i]));
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            o = snap0();
            chk($sformatf("lwrst enables %0d", i),
                32'({o.pcen, o.irwrite, o.memwrite, o.regwrite}), 32'(0));
            o = snap1();
            chk($sformatf("lwrst enables1 %0d", i),
                32'({o.pcen, o.irwrite, o.memwrite, o.regwrite}), 32'(0));
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("lwrst fetch dut0", 32'(snap0()), 32'(fetch_o()));
        chk("lwrst fetch dut1", 32'(snap1()), 32'(fetch_o()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
